// File: rtl/vend_cfg_pkg.sv
// vend_cfg_pkg: address map, item word fields and op encodings for the vend item table
package vend_cfg_pkg;
  localparam logic [31:0] CSR_ITEMS   = 32'h0000;
  localparam logic [31:0] CSR_MODE    = 32'h0004;
  localparam logic [31:0] CSR_SOLDOUT = 32'h0008;
  localparam logic [31:0] ITEM_BASE   = 32'h1000;
  localparam int COST_LSB  = 0;
  localparam int COST_W    = 16;
  localparam int AVAIL_LSB = 16;
  localparam int AVAIL_W   = 8;
  localparam int SOLD_LSB  = 24;
  localparam int SOLD_W    = 8;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_VEND = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2} apb_st_t;
  function automatic logic [SOLD_W-1:0] sat_inc(input logic [SOLD_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/vend_rr_arb.sv
// vend_rr_arb: round-robin arbiter, lowest requester at or after the pointer wins
module vend_rr_arb #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] req,
  input  logic              block,
  output logic [NUM_CH-1:0] gnt,
  output logic [2:0]        win
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PW-1:0] ptr;
  logic [NUM_CH-1:0] hi, pick;
  always_comb begin
    hi = req & ~((NUM_CH'(1) << ptr) - NUM_CH'(1));
    pick = |hi ? hi : req;
    win = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (pick[c]) win = 3'(c);
    gnt = (!block && |req) ? NUM_CH'(1) << win : '0;
  end
  always_ff @(posedge clk)
    if (!rstn) ptr <= '0;
    else if (|gnt) ptr <= int'(win) == NUM_CH - 1 ? '0 : PW'(win + 3'd1);
endmodule

// File: rtl/vend_item_table.sv
// vend_item_table: APB-configured item table shared by round-robin vend channels; VEND_SOLDOUT_IRQ_EN adds soldout status/irq
module vend_item_table
  import vend_cfg_pkg::*;
#(
  parameter int MAX_ITEMS = 1024,
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 15,
  localparam int ID_W = $clog2(MAX_ITEMS)
) (
  input  logic                   pclk,
  input  logic                   prstn,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH-1:0]      ch_op,
  input  logic [NUM_CH*ID_W-1:0] ch_id,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic                   rsp_vld,
  output logic [2:0]             rsp_ch,
  output logic                   rsp_ok,
  output logic [15:0]            rsp_cost,
  output logic [7:0]             rsp_avail,
  output logic                   cfg_mode,
  output logic                   soldout_irq
);
  apb_st_t st, st_nx;
  logic acc1, is_items, is_mode, is_sold, is_item, err, ok_wr;
  logic [31:0] addr, off, csr_rd, csr_q;
  logic [ID_W-1:0] apb_idx, sel_id, g_id, ra, wa;
  logic err_q, itm_q;
  logic [ID_W:0] n_items;
  logic [NUM_CH-1:0] sold_st, gnt;
  logic [2:0] win, g_ch;
  logic sel_op, g_vld, g_op, g_mode, g_inr, r_vld, vend_ok, we, fwd_vld;
  logic [31:0] mem [MAX_ITEMS];
  logic [31:0] rd_q, fwd_q, ram_out, wd, wb_word;
  logic [7:0] avail;
  assign addr = 32'(paddr);
  assign off = addr - ITEM_BASE;
  assign acc1 = st == S_ACC1 && psel && penable;
  assign is_items = addr == CSR_ITEMS;
  assign is_mode = addr == CSR_MODE;
  assign is_sold = addr == CSR_SOLDOUT;
  assign is_item = addr >= ITEM_BASE && off[1:0] == 2'b00 && (off >> 2) < 32'(MAX_ITEMS);
  assign apb_idx = off[ID_W+1:2];
  assign err = !(is_items || is_mode || is_sold || is_item) || (is_item && pwrite && !cfg_mode);
  assign ok_wr = acc1 && pwrite && !err;
  assign csr_rd = is_items ? 32'(n_items) : is_mode ? 32'(cfg_mode) : is_sold ? 32'(sold_st) : '0;
  always_comb
    st_nx = st == S_IDLE ? (psel && !penable ? S_ACC1 : S_IDLE) :
            st == S_ACC1 ? (psel && penable ? S_ACC2 : S_IDLE) : S_IDLE;
  always_ff @(posedge pclk)
    if (!prstn) begin
      st <= S_IDLE;
      n_items <= '0;
      cfg_mode <= 1'b1;
      err_q <= 1'b0;
      itm_q <= 1'b0;
      csr_q <= '0;
      g_vld <= 1'b0;
    end else begin
      st <= st_nx;
      if (acc1) begin
        err_q <= err;
        itm_q <= is_item;
        csr_q <= csr_rd;
      end
      if (ok_wr && is_items) n_items <= pwdata > 32'(MAX_ITEMS) ? (ID_W+1)'(MAX_ITEMS) : pwdata[ID_W:0];
      if (ok_wr && is_mode) cfg_mode <= pwdata[0];
      g_vld <= |gnt;
      g_ch <= win;
      g_op <= sel_op;
      g_id <= sel_id;
      g_mode <= cfg_mode;
      g_inr <= {1'b0, sel_id} < n_items;
    end
  assign pready = st == S_ACC2;
  assign pslverr = pready && err_q;
  assign prdata = pready && !err_q ? (itm_q ? ram_out : csr_q) : '0;
  vend_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk(pclk), .rstn(prstn), .req(ch_req), .block(acc1 || !prstn), .gnt(gnt), .win(win)
  );
  assign ch_ack = gnt;
  always_comb begin
    sel_op = OP_READ;
    sel_id = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (gnt[c]) begin
        sel_op = ch_op[c];
        sel_id = ch_id[c*ID_W +: ID_W];
      end
  end
  // A same-cycle write to the address being read is forwarded so no reader sees stale RAM
  assign ra = acc1 ? apb_idx : sel_id;
  assign we = vend_ok || (ok_wr && is_item);
  assign wa = vend_ok ? g_id : apb_idx;
  assign wd = vend_ok ? wb_word : pwdata;
  always_ff @(posedge pclk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
    fwd_vld <= we && wa == ra;
    fwd_q <= wd;
  end
  assign ram_out = fwd_vld ? fwd_q : rd_q;
  assign r_vld = g_vld && prstn;
  assign avail = ram_out[AVAIL_LSB +: AVAIL_W];
  assign vend_ok = r_vld && g_op == OP_VEND && !g_mode && g_inr && avail != 8'd0;
  assign wb_word = {sat_inc(ram_out[SOLD_LSB +: SOLD_W]), avail - 8'd1, ram_out[COST_LSB +: COST_W]};
  assign rsp_vld = r_vld;
  assign rsp_ch = r_vld ? g_ch : '0;
  assign rsp_ok = r_vld && (g_op == OP_READ ? g_inr : vend_ok);
  assign rsp_cost = r_vld ? ram_out[COST_LSB +: COST_W] : '0;
  assign rsp_avail = !r_vld ? '0 : vend_ok ? avail - 8'd1 : avail;
`ifdef VEND_SOLDOUT_IRQ_EN
  logic irq_q;
  always_ff @(posedge pclk)
    if (!prstn) begin
      sold_st <= '0;
      irq_q <= 1'b0;
    end else begin
      sold_st <= (ok_wr && is_sold ? sold_st & ~pwdata[NUM_CH-1:0] : sold_st) |
                 (vend_ok && avail == 8'd1 ? NUM_CH'(1) << g_ch : '0);
      irq_q <= |sold_st;
    end
  assign soldout_irq = irq_q;
`else
  assign sold_st = '0;
  assign soldout_irq = 1'b0;
`endif
endmodule

// File: tb/tb_vend_item_table.sv
// tb_vend_item_table: scoreboard bench for vend_item_table (APB map, vends, arbitration, forwarding)
module tb_vend_item_table;
  localparam int MAX_ITEMS = 1024;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 15;
  localparam int ID_W = 10;
  typedef struct packed {
    logic [2:0] ch;
    logic ok;
    logic [15:0] cost;
    logic [7:0] avail;
  } rsp_t;
  logic pclk = 1'b0, prstn = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0, prdata;
  logic pready, pslverr;
  logic [NUM_CH-1:0] ch_req = '0, ch_op = '0, ch_ack;
  logic [NUM_CH*ID_W-1:0] ch_id = '0;
  logic rsp_vld, rsp_ok, cfg_mode, soldout_irq;
  logic [2:0] rsp_ch;
  logic [15:0] rsp_cost;
  logic [7:0] rsp_avail;
  int n_tests = 0, n_fail = 0;
  rsp_t sb[$];
  int ack_log[$];
  logic [31:0] mdl [MAX_ITEMS];
  int m_items = 0;
  logic m_mode = 1'b1;
  vend_item_table #(.MAX_ITEMS(MAX_ITEMS), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .prstn(prstn), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ch_req(ch_req), .ch_op(ch_op), .ch_id(ch_id), .ch_ack(ch_ack),
    .rsp_vld(rsp_vld), .rsp_ch(rsp_ch), .rsp_ok(rsp_ok), .rsp_cost(rsp_cost), .rsp_avail(rsp_avail),
    .cfg_mode(cfg_mode), .soldout_irq(soldout_irq)
  );
  always #5 pclk = ~pclk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic monitor();
    forever begin
      @(negedge pclk);
      if (prstn && pready && pwrite && !pslverr) begin
        if (paddr == 0) m_items = pwdata > 32'(MAX_ITEMS) ? MAX_ITEMS : int'(pwdata);
        if (paddr == 4) m_mode = pwdata[0];
        if (paddr >= 15'h1000 && paddr < 15'h2000 && paddr[1:0] == 2'b00) mdl[(int'(paddr) - 'h1000) / 4] = pwdata;
      end
      if (prstn && rsp_vld) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected got ch=%0d exp no response", rsp_ch);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          if ({rsp_ch, rsp_ok, rsp_cost, rsp_avail} !== e) begin
            n_fail++;
            $display("FAIL rsp ch/ok/cost/avail got %0d/%0d/%h/%0d exp %0d/%0d/%h/%0d",
                     rsp_ch, rsp_ok, rsp_cost, rsp_avail, e.ch, e.ok, e.cost, e.avail);
          end
        end
      end
      if (prstn && |ch_ack) begin
        n_tests++;
        if ($countones(ch_ack) != 1) begin
          n_fail++;
          $display("FAIL ack_onehot got %b exp one-hot", ch_ack);
        end
        for (int c = 0; c < NUM_CH; c++)
          if (ch_ack[c]) begin
            int id;
            logic [31:0] w;
            logic inr;
            rsp_t e;
            id = int'(ch_id[c*ID_W +: ID_W]);
            w = mdl[id];
            inr = id < m_items;
            e.ch = 3'(c);
            e.cost = w[15:0];
            e.ok = 1'b0;
            e.avail = w[23:16];
            if (ch_op[c] == 1'b0) e.ok = inr;
            else if (!m_mode && inr && w[23:16] != 8'd0) begin
              e.ok = 1'b1;
              e.avail = w[23:16] - 8'd1;
              mdl[id] = {w[31:24] == 8'hFF ? 8'hFF : w[31:24] + 8'd1, e.avail, w[15:0]};
            end
            sb.push_back(e);
            ack_log.push_back(c);
          end
      end
    end
  endtask
  task automatic apb(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] wdat,
                     output logic [31:0] rd, output logic err, output int w, output logic [NUM_CH-1:0] ack1);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wdat;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    ack1 = ch_ack;
    w = 0;
    while (pready !== 1'b1 && w < 8) begin
      w++;
      @(negedge pclk);
    end
    rd = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask
  task automatic ch_do(input int c, input logic op, input logic [ID_W-1:0] id);
    int t;
    @(posedge pclk); #1;
    ch_req[c] = 1'b1; ch_op[c] = op; ch_id[c*ID_W +: ID_W] = id;
    t = 0;
    @(negedge pclk);
    while (!ch_ack[c] && t < 20) begin
      t++;
      @(negedge pclk);
    end
    if (t >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL ch_ack_timeout got no ack exp ack on ch%0d", c);
    end
    @(posedge pclk); #1;
    ch_req[c] = 1'b0;
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge pclk);
      t++;
    end
    @(negedge pclk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout got %0d pending exp 0", sb.size());
    end
  endtask
  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    int w;
    logic [NUM_CH-1:0] a1;
    prstn = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    n_tests++;
    if ({pready, pslverr, prdata, ch_ack, rsp_vld, rsp_ch, rsp_ok, rsp_cost, rsp_avail, soldout_irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got pready=%b prdata=%h rsp_vld=%b exp all 0", pready, prdata, rsp_vld);
    end
    n_tests++;
    if (cfg_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cfg_mode got %b exp 1", cfg_mode);
    end
    @(posedge pclk); #1;
    prstn = 1'b1;
    apb(1'b0, 15'h0004, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'd1 || err !== 1'b0 || w !== 1) begin
      n_fail++;
      $display("FAIL rd_mode got %h/%b/%0d exp 00000001/0/1", rd, err, w);
    end
    apb(1'b0, 15'h0000, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'd0 || err !== 1'b0 || w !== 1) begin
      n_fail++;
      $display("FAIL rd_items got %h/%b/%0d exp 00000000/0/1", rd, err, w);
    end
  endtask
  task automatic test_item_rw();
    logic [31:0] rd;
    logic err;
    int w;
    logic [NUM_CH-1:0] a1;
    apb(1'b1, 15'h1014, 32'h0003_0032, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b0 || w !== 1) begin
      n_fail++;
      $display("FAIL wr_item5 got err=%b wait=%0d exp 0/1", err, w);
    end
    apb(1'b0, 15'h1014, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'h0003_0032 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_item5 got %h/%b exp 00030032/0", rd, err);
    end
    apb(1'b1, 15'h1008, 32'h0002_0010, rd, err, w, a1);
    apb(1'b1, 15'h1024, 32'h0005_0020, rd, err, w, a1);
    apb(1'b1, 15'h0000, 32'd8, rd, err, w, a1);
    apb(1'b1, 15'h0004, 32'd0, rd, err, w, a1);
    n_tests++;
    if (cfg_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_mode_clear got %b exp 0", cfg_mode);
    end
    apb(1'b1, 15'h1014, 32'hDEAD_BEEF, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL wr_item_locked got err=%b rd=%h exp 1/00000000", err, rd);
    end
    apb(1'b0, 15'h1014, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'h0003_0032) begin
      n_fail++;
      $display("FAIL item5_unchanged got %h exp 00030032", rd);
    end
  endtask
  task automatic test_vend();
    logic [31:0] rd;
    logic err;
    int w;
    logic [NUM_CH-1:0] a1;
    repeat (3) ch_do(0, 1'b1, 10'd5);
    wait_drain();
    repeat (3) @(negedge pclk);
`ifdef VEND_SOLDOUT_IRQ_EN
    n_tests++;
    if (soldout_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL soldout_irq_set got %b exp 1", soldout_irq);
    end
`else
    n_tests++;
    if (soldout_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL soldout_irq_off got %b exp 0", soldout_irq);
    end
`endif
    ch_do(0, 1'b1, 10'd5);
    wait_drain();
    apb(1'b0, 15'h1014, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'h0300_0032) begin
      n_fail++;
      $display("FAIL item5_after_vend got %h exp 03000032", rd);
    end
`ifdef VEND_SOLDOUT_IRQ_EN
    apb(1'b0, 15'h0008, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'd1) begin
      n_fail++;
      $display("FAIL soldout_status got %h exp 00000001", rd);
    end
    apb(1'b1, 15'h0008, 32'd1, rd, err, w, a1);
    apb(1'b0, 15'h0008, 0, rd, err, w, a1);
    repeat (2) @(negedge pclk);
    n_tests++;
    if (rd !== 32'd0 || soldout_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL soldout_w1c got %h/%b exp 00000000/0", rd, soldout_irq);
    end
`else
    apb(1'b1, 15'h0008, 32'd1, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL soldout_wr_off got err=%b exp 0", err);
    end
    apb(1'b0, 15'h0008, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL soldout_rd_off got %h/%b exp 00000000/0", rd, err);
    end
`endif
  endtask
  task automatic test_rr();
    logic [31:0] rd;
    logic err;
    int w, b;
    logic [NUM_CH-1:0] a1;
    b = ack_log.size();
    @(posedge pclk); #1;
    ch_op = '0;
    ch_id = {10'd5, 10'd5};
    ch_req = 2'b11;
    repeat (4) @(negedge pclk);
    apb(1'b0, 15'h1014, 0, rd, err, w, a1);
    n_tests++;
    if (a1 !== 2'b00 || rd !== 32'h0300_0032 || w !== 1) begin
      n_fail++;
      $display("FAIL rr_apb_insert got ack=%b rd=%h wait=%0d exp 00/03000032/1", a1, rd, w);
    end
    repeat (3) @(negedge pclk);
    @(posedge pclk); #1;
    ch_req = '0;
    wait_drain();
    n_tests++;
    if (ack_log.size() - b < 8) begin
      n_fail++;
      $display("FAIL rr_ack_count got %0d exp >=8", ack_log.size() - b);
    end
    for (int i = b + 1; i < ack_log.size(); i++) begin
      n_tests++;
      if (ack_log[i] == ack_log[i-1]) begin
        n_fail++;
        $display("FAIL rr_alternate got ch%0d twice at %0d exp alternating", ack_log[i], i - b);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] rd;
    logic err;
    int w;
    logic [NUM_CH-1:0] a1;
    fork
      ch_do(0, 1'b1, 10'd2);
      begin
        @(posedge pclk);
        ch_do(1, 1'b1, 10'd2);
      end
    join
    wait_drain();
    apb(1'b0, 15'h1008, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'h0200_0010) begin
      n_fail++;
      $display("FAIL b2b_item2 got %h exp 02000010", rd);
    end
  endtask
  task automatic test_errors();
    logic [31:0] rd;
    logic err;
    int w;
    logic [NUM_CH-1:0] a1;
    ch_do(0, 1'b1, 10'd9);
    wait_drain();
    apb(1'b0, 15'h1024, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'h0005_0020 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL item9_unchanged got %h/%b exp 00050020/0", rd, err);
    end
    apb(1'b0, 15'h0003, 0, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'd0 || w !== 1) begin
      n_fail++;
      $display("FAIL unaligned got err=%b rd=%h wait=%0d exp 1/00000000/1", err, rd, w);
    end
    apb(1'b0, 15'h2000, 0, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL item_oob got err=%b exp 1", err);
    end
    apb(1'b0, 15'h000C, 0, rd, err, w, a1);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped got err=%b exp 1", err);
    end
    apb(1'b1, 15'h0000, 32'd5000, rd, err, w, a1);
    apb(1'b0, 15'h0000, 0, rd, err, w, a1);
    n_tests++;
    if (rd !== 32'd1024 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL items_clamp got %0d/%b exp 1024/0", rd, err);
    end
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_item_rw();
    test_vend();
    test_rr();
    test_back_to_back();
    test_errors();
    repeat (3) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
